// File: rtl/cmp_serial_msb_pkg.sv
// Shared definitions for the bit-serial MSB-first comparator: FSM states,
// one-hot result codes and the per-bit result helper.
package cmp_serial_msb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result codes are ordered {Go, Eo, Lo}.
  localparam logic [2:0] RES_G    = 3'b100;
  localparam logic [2:0] RES_E    = 3'b010;
  localparam logic [2:0] RES_L    = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  function automatic logic [2:0] bit_res(input logic a, input logic b);
    if (a && !b)      return RES_G;
    else if (!a && b) return RES_L;
    else              return RES_E;
  endfunction

endpackage

// File: rtl/cmp_msb_step.sv
// One-bit MSB-first decision cell: decides when the bit pair differs or when
// it is the last bit, and reports the one-hot outcome for that bit pair.
module cmp_msb_step
  import cmp_serial_msb_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       last,
  output logic       dec,
  output logic [2:0] res
);

  assign dec = (a ^ b) | last;
  assign res = bit_res(a, b);

endmodule

// File: rtl/cmp_serial_msb.sv
// Bit-serial unsigned magnitude comparator, one bit pair per clock from the
// MSB, with early exit on the first differing bit.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | in_ready=1, waiting for operands
//   ST_SCAN | comparing shift-register MSBs, one bit per cycle
//   ST_DONE | out_valid=1, result held until out_ready
module cmp_serial_msb
  import cmp_serial_msb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         Go,
  output logic         Eo,
  output logic         Lo
);

  localparam int CW = $clog2(N + 1);

  state_t        state, state_nx;
  logic [N-1:0]  a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic [2:0]    res_q;

  logic          step_dec;
  logic [2:0]    step_res;
  logic          cap, shift, set_res, clr_res;

  cmp_msb_step u_step (
    .a    (a_sh[N-1]),
    .b    (b_sh[N-1]),
    .last (cnt == CW'(1)),
    .dec  (step_dec),
    .res  (step_res)
  );

  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    shift    = 1'b0;
    set_res  = 1'b0;
    clr_res  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          cap      = 1'b1;
          state_nx = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (step_dec) begin
          set_res  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          shift = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          clr_res  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      res_q <= RES_NONE;
    end else begin
      state <= state_nx;
      if (cap) begin
        a_sh <= A;
        b_sh <= B;
        cnt  <= CW'(N);
      end else if (shift) begin
        a_sh <= a_sh << 1;
        b_sh <= b_sh << 1;
        cnt  <= cnt - CW'(1);
      end
      if (set_res)      res_q <= step_res;
      else if (clr_res) res_q <= RES_NONE;
    end
  end

  // Handshake outputs come straight from the state register.
  assign in_ready     = (state == ST_IDLE);
  assign out_valid    = (state == ST_DONE);
  assign {Go, Eo, Lo} = res_q;

endmodule

// File: tb/tb_cmp_serial_msb.sv
// Directed and randomized checks of cmp_serial_msb at N=1, N=8 and N=13.
module tb_cmp_serial_msb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin  [3];
  logic        ordy [3];
  logic        rdy  [3];
  logic        ov   [3];
  logic        go   [3];
  logic        eo   [3];
  logic        lo   [3];
  logic [12:0] a_v  [3];
  logic [12:0] b_v  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cmp_serial_msb #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(rdy[0]),
    .A(a_v[0][0:0]), .B(b_v[0][0:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .Go(go[0]), .Eo(eo[0]), .Lo(lo[0])
  );

  cmp_serial_msb #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(rdy[1]),
    .A(a_v[1][7:0]), .B(b_v[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .Go(go[1]), .Eo(eo[1]), .Lo(lo[1])
  );

  cmp_serial_msb #(.N(13)) u_dut13 (
    .clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(rdy[2]),
    .A(a_v[2][12:0]), .B(b_v[2][12:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .Go(go[2]), .Eo(eo[2]), .Lo(lo[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] res_of(input int d);
    return {go[d], eo[d], lo[d]};
  endfunction

  function automatic logic [2:0] model_res(input logic [12:0] a, input logic [12:0] b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic int model_k(input logic [12:0] a, input logic [12:0] b, input int n);
    for (int i = n - 1; i >= 0; i--)
      if (a[i] != b[i]) return n - i;
    return n;
  endfunction

  // One directed transaction on the N=8 instance, out_ready held high.
  task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] er, input int ek);
    int lat;
    lat = 0;
    a_v[1] = {5'd0, a};
    b_v[1] = {5'd0, b};
    vin[1]  = 1'b1;
    ordy[1] = 1'b1;
    chk({tag, "_in_ready"}, 32'(rdy[1]), 32'd1);
    tick();
    vin[1] = 1'b0;
    a_v[1] = ~a_v[1];
    while (!ov[1] && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(ek));
    chk({tag, "_result"}, 32'(res_of(1)), 32'(er));
    tick();
    chk({tag, "_ready_after"}, 32'(rdy[1]), 32'd1);
    chk({tag, "_valid_after"}, 32'(ov[1]), 32'd0);
    chk({tag, "_cleared"}, 32'(res_of(1)), 32'd0);
  endtask

  task automatic pick(input int d, input int n);
    logic [12:0] mask, a, b;
    int sel;
    mask = 13'((32'd1 << n) - 1);
    a    = 13'($urandom) & mask;
    sel  = $urandom_range(0, 3);
    case (sel)
      0:       b = a;
      1:       b = a ^ 13'(32'd1 << $urandom_range(0, n - 1));
      default: b = 13'($urandom) & mask;
    endcase
    a_v[d] = a;
    b_v[d] = b;
  endtask

  // Back-to-back stream with in_valid and out_ready held high.
  task automatic run_random(input int d, input int n, input int count);
    int cyc, acc, done, budget, ek;
    logic [2:0] er;
    logic want_rdy;
    cyc = 0; acc = -1; done = 0; ek = 0; er = 3'b000; want_rdy = 1'b0;
    budget = count * (n + 3) + 50;
    pick(d, n);
    vin[d]  = 1'b1;
    ordy[d] = 1'b1;
    while (done < count && cyc < budget) begin
      if (want_rdy) begin
        chk($sformatf("rnd%0d_ready_after", n), 32'(rdy[d]), 32'd1);
        want_rdy = 1'b0;
      end
      if (ov[d]) begin
        chk($sformatf("rnd%0d_result", n), 32'(res_of(d)), 32'(er));
        chk($sformatf("rnd%0d_latency", n), 32'(cyc - acc), 32'(ek));
        done++;
        want_rdy = 1'b1;
      end
      if (rdy[d]) begin
        acc = cyc + 1;
        er  = model_res(a_v[d], b_v[d]);
        ek  = model_k(a_v[d], b_v[d], n);
      end
      tick();
      cyc++;
      if (acc == cyc) pick(d, n);
    end
    chk($sformatf("rnd%0d_completed", n), 32'(done), 32'(count));
    vin[d] = 1'b0;
    while (!rdy[d] && cyc < budget + 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; ordy[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(rdy[1]), 32'd1);
    chk("rst_out_valid", 32'(ov[1]), 32'd0);
    chk("rst_result", 32'(res_of(1)), 32'd0);
    rst = 1'b0;
    tick();

    txn("equal_a5", 8'hA5, 8'hA5, 3'b010, 8);
    txn("msb_diff", 8'h80, 8'h7F, 3'b100, 1);
    txn("lsb_diff", 8'h12, 8'h13, 3'b001, 8);
    txn("mid_diff", 8'h5C, 8'h54, 3'b100, 5);

    // Back-pressure: result must hold and new operands must be ignored.
    a_v[1] = 13'h40; b_v[1] = 13'h20; vin[1] = 1'b1; ordy[1] = 1'b0;
    tick();
    vin[1] = 1'b0;
    tick();
    tick();
    chk("bp_valid", 32'(ov[1]), 32'd1);
    chk("bp_result", 32'(res_of(1)), 32'b100);
    for (int i = 0; i < 5; i++) begin
      vin[1] = (i % 2 == 0);
      a_v[1] = 13'h01; b_v[1] = 13'hFF;
      tick();
      chk("bp_hold_valid", 32'(ov[1]), 32'd1);
      chk("bp_hold_result", 32'(res_of(1)), 32'b100);
      chk("bp_hold_in_ready", 32'(rdy[1]), 32'd0);
    end
    vin[1] = 1'b0; ordy[1] = 1'b1;
    tick();
    chk("bp_release_ready", 32'(rdy[1]), 32'd1);
    tick();
    chk("bp_no_second", 32'(ov[1]), 32'd0);

    // Reset during the third SCAN cycle aborts the transaction.
    a_v[1] = 13'h01; b_v[1] = 13'h00; vin[1] = 1'b1;
    tick();
    vin[1] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_in_ready", 32'(rdy[1]), 32'd1);
    chk("rstmid_out_valid", 32'(ov[1]), 32'd0);
    chk("rstmid_result", 32'(res_of(1)), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov[1]) seen = 1'b1;
    end
    chk("rstmid_no_result", 32'(seen), 32'd0);

    txn("post_rst", 8'h00, 8'h01, 3'b001, 8);

    run_random(1, 8, 1000);
    run_random(0, 1, 200);
    run_random(2, 13, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
